// File: rtl/dpram_fifo_ctrl.sv
// dpram_fifo_ctrl: FWFT FIFO controller for an external one-cycle-latency dual-port RAM.
// Define DPRAM_FIFO_CTRL_HWM_EN to add the hwm high-water-mark port.
module dpram_fifo_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [ADDR_WIDTH+1:0] count,
`ifdef DPRAM_FIFO_CTRL_HWM_EN
    output logic [ADDR_WIDTH+1:0] hwm,
`endif
    output logic [ADDR_WIDTH-1:0] ram_addr_a,
    output logic [DATA_WIDTH-1:0] ram_data_a,
    output logic                  ram_we_a,
    output logic [ADDR_WIDTH-1:0] ram_addr_b,
    output logic                  ram_we_b,
    input  logic [DATA_WIDTH-1:0] ram_q_b
);
    localparam int CW = ADDR_WIDTH + 2;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   used_q, used_d;
    logic                  infl_q, infl_d;
    logic [1:0]            ocnt_q, ocnt_d, ocnt_pop;
    logic [DATA_WIDTH-1:0] b0_q, b0_d, b1_q, b1_d;
    logic                  wr, pop, issue;
    // used_q never exceeds DEPTH, so its MSB alone flags full
    assign s_ready    = rst_n && !used_q[ADDR_WIDTH];
    assign wr         = s_valid && s_ready;
    assign m_valid    = ocnt_q != 2'd0;
    assign m_data     = b0_q;
    assign pop        = m_valid && m_ready;
    assign issue      = used_q != '0 && ({1'b0, ocnt_q} + {2'b0, infl_q} - {2'b0, pop}) < 3'd2;
    assign ram_we_a   = wr;
    assign ram_addr_a = wr_ptr_q;
    assign ram_data_a = s_data;
    assign ram_addr_b = rd_ptr_q;
    assign ram_we_b   = 1'b0;
    assign count      = CW'(used_q) + CW'(infl_q) + CW'(ocnt_q);
    always_comb begin
        wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(wr);
        rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(issue);
        used_d   = used_q + (ADDR_WIDTH+1)'(wr) - (ADDR_WIDTH+1)'(issue);
        infl_d   = issue;
        ocnt_pop = ocnt_q - 2'(pop);
        ocnt_d   = ocnt_pop + 2'(infl_q);
        b0_d     = infl_q && ocnt_pop == 2'd0 ? ram_q_b : pop ? b1_q : b0_q;
        b1_d     = infl_q && ocnt_pop != 2'd0 ? ram_q_b : b1_q;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            used_q   <= '0;
            infl_q   <= 1'b0;
            ocnt_q   <= 2'd0;
            b0_q     <= '0;
            b1_q     <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            used_q   <= used_d;
            infl_q   <= infl_d;
            ocnt_q   <= ocnt_d;
            b0_q     <= b0_d;
            b1_q     <= b1_d;
        end
    end
`ifdef DPRAM_FIFO_CTRL_HWM_EN
    localparam logic [CW-1:0] CAP = CW'(2**ADDR_WIDTH + 2);
    logic [CW-1:0] count_d, hwm_q, hwm_d;
    assign count_d = CW'(used_d) + CW'(infl_d) + CW'(ocnt_d);
    assign hwm_d   = count_d > hwm_q ? (count_d > CAP ? CAP : count_d) : hwm_q;
    assign hwm     = hwm_q;
    always_ff @(posedge clk) begin
        hwm_q <= !rst_n ? '0 : hwm_d;
    end
`endif
endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// tb_dpram_fifo_ctrl: randomized and directed checks of dpram_fifo_ctrl against a queue-level occupancy model.
module tb_dpram_fifo_ctrl;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic [15:0] s_data = '0, m_data, ram_data_a, ram_q_b;
    logic        s_valid = 1'b0, s_ready, m_valid, m_ready = 1'b0;
    logic [6:0]  count;
    logic [4:0]  ram_addr_a, ram_addr_b;
    logic        ram_we_a, ram_we_b;
    logic [15:0] mem [32];
`ifdef DPRAM_FIFO_CTRL_HWM_EN
    logic [6:0]  hwm;
`endif
    dpram_fifo_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(5)) dut (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .count(count),
`ifdef DPRAM_FIFO_CTRL_HWM_EN
        .hwm(hwm),
`endif
        .ram_addr_a(ram_addr_a), .ram_data_a(ram_data_a), .ram_we_a(ram_we_a),
        .ram_addr_b(ram_addr_b), .ram_we_b(ram_we_b), .ram_q_b(ram_q_b)
    );
    always #5 clk = ~clk;
    always @(posedge clk) begin
        if (ram_we_a) mem[ram_addr_a] <= ram_data_a;
        ram_q_b <= mem[ram_addr_b];
    end
    int vecs = 0, errs = 0;
    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    // Model: words sitting in RAM, a read in flight, words buffered; data order from sb
    logic [15:0] sb[$];
    int ram_n, ob_n, infl_m, hwm_m, wa;
    function automatic int cnt_m();
        return ram_n + infl_m + ob_n;
    endfunction
    task automatic model_clear();
        sb.delete();
        ram_n = 0; ob_n = 0; infl_m = 0; hwm_m = 0; wa = 0;
    endtask
    task automatic step(input bit sv, input logic [15:0] sd, input bit mr);
        int sr, mv, wr, pop, iss;
        s_valid = sv; s_data = sd; m_ready = mr;
        #1;
        sr = ram_n < 32; mv = ob_n > 0; wr = sv && sr; pop = mv && mr;
        expect_eq("s_ready", s_ready, sr);
        expect_eq("m_valid", m_valid, mv);
        if (mv) expect_eq("m_data", m_data, sb[0]);
        expect_eq("count", count, cnt_m());
        expect_eq("we_a", ram_we_a, wr);
        expect_eq("we_b", ram_we_b, 0);
        if (wr) begin
            expect_eq("addr_a", ram_addr_a, wa);
            expect_eq("data_a", ram_data_a, sd);
        end
`ifdef DPRAM_FIFO_CTRL_HWM_EN
        expect_eq("hwm", hwm, hwm_m);
`endif
        iss = ram_n > 0 && ob_n + infl_m - pop < 2;
        @(posedge clk);
        if (pop) void'(sb.pop_front());
        if (wr) sb.push_back(sd);
        ob_n = ob_n - pop + infl_m;
        infl_m = iss;
        ram_n = ram_n - iss + wr;
        wa = (wa + wr) % 32;
        if (cnt_m() > hwm_m) hwm_m = cnt_m();
        #1;
    endtask
    task automatic do_reset();
        rst_n = 1'b0; s_valid = 1'b1; m_ready = 1'b1;
        #1;
        expect_eq("rst_s_ready", s_ready, 0);
        expect_eq("rst_we_a", ram_we_a, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1; s_valid = 1'b0;
        model_clear();
        expect_eq("rst_count", count, 0);
        expect_eq("rst_m_valid", m_valid, 0);
        expect_eq("rst_m_data", m_data, 0);
`ifdef DPRAM_FIFO_CTRL_HWM_EN
        expect_eq("rst_hwm", hwm, 0);
`endif
    endtask
    initial begin
        int acc, pops;
        model_clear();
        do_reset();
        step(1'b1, 16'hA5A5, 1'b1);
        step(1'b0, '0, 1'b1);
        expect_eq("lat_c2", m_valid, 0);
        step(1'b0, '0, 1'b1);
        expect_eq("lat_c3", m_valid, 1);
        expect_eq("lat_data", m_data, 16'hA5A5);
        step(1'b0, '0, 1'b1);
        expect_eq("lat_cnt0", count, 0);
        acc = 0;
        for (int i = 0; i < 40; i++) begin
            acc += int'(s_ready);
            step(1'b1, 16'(acc - int'(s_ready)), 1'b0);
        end
        expect_eq("full_acc", acc, 34);
        expect_eq("full_cnt", count, 34);
        expect_eq("full_rdy", s_ready, 0);
        for (int i = 0; i < 36; i++) step(1'b0, '0, 1'b1);
        expect_eq("drain_cnt", count, 0);
        expect_eq("drain_mv", m_valid, 0);
        pops = 0;
        for (int i = 0; i < 203; i++) begin
            if (i >= 3) expect_eq("stream_nobubble", m_valid, 1);
            pops += int'(m_valid);
            step(i < 200, 16'(i + 100), 1'b1);
        end
        expect_eq("stream_pops", pops, 200);
        for (int i = 0; i < 10000; i++) step(1'($urandom), 16'($urandom), 1'($urandom));
        for (int i = 0; i < 40; i++) step(1'b0, '0, 1'b1);
        expect_eq("rand_drain", count, 0);
        while (cnt_m() < 20) step(1'b1, 16'($urandom), 1'b0);
        step(1'b1, 16'($urandom), 1'b1);
        expect_eq("pre_rst_cnt", count, 20);
        expect_eq("pre_rst_infl", infl_m, 1);
        do_reset();
        step(1'b1, 16'h1234, 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        expect_eq("post_rst_mv", m_valid, 1);
        expect_eq("post_rst_data", m_data, 16'h1234);
        step(1'b0, '0, 1'b1);
        expect_eq("post_rst_cnt", count, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
